text_dump_tx: RTL
=================

# text_dump_tx

Serializes the text-mode character buffer out over UART (8N1) on request, row by row, ending each row with CR/LF. It is the transmit counterpart of the UART-receive path that writes ASCII characters into the display buffer. It runs in the 25 MHz pixel clock domain alongside the VGA core and reads the buffer through a spare synchronous read port. It lets the host capture the current screen contents.

## Interface
Parameters:
- CLKS_PER_BIT, 2604, clock cycles per UART bit (25 MHz / 9600 baud)
- COLS, 80, characters per row
- ROWS, 30, rows per screen

Ports:
- clk  in  1  single clock, 25 MHz
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request tick to begin a dump; ignored while busy
- rd_addr  out  12  buffer read address = {row[4:0], col[6:0]}
- rd_data  in  7  ASCII code, valid on the cycle after rd_addr changes (1-cycle synchronous RAM)
- tx  out  1  UART line, idle high
- busy  out  1  high from the cycle after start is accepted until the dump completes
- done_tick  out  1  one-cycle pulse when the final LF stop bit completes

## Operation
- Reset values: tx=1, busy=0, done_tick=0, rd_addr=0. All state returns to IDLE. Reset mid-frame forces tx high immediately (asynchronously).
- FSM states: IDLE, FETCH, WAIT, LOAD, SEND, EOL_CR, EOL_LF, FINISH.
- IDLE: if start=1, clear the row and column counters and go to FETCH. busy rises.
- FETCH: drive rd_addr={row,col} and go to WAIT.
- WAIT: capture rd_data into the byte register, then go to LOAD.
- Substitution: rd_data < 0x20 or = 0x7F is sent as 0x20 (space). The 8th bit is always 0.
- LOAD: pulse tx_start to the serializer with the byte, then go to SEND.
- SEND: wait for the serializer done. Then:
  - if col < COLS-1: col++ and go to FETCH;
  - otherwise go to EOL_CR.
- EOL_CR: send 0x0D (the same LOAD/SEND handshake), then go to EOL_LF.
- EOL_LF: send 0x0A. Then:
  - if row < ROWS-1: row++, col=0, and go to FETCH;
  - otherwise go to FINISH.
- FINISH: done_tick=1 for one cycle, busy=0, go to IDLE.
- Total bytes per dump = ROWS*(COLS+2); the default is 2460.
- start while busy is dropped. It is not queued.
- Serializer:
  - frame = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1);
  - each bit is held exactly CLKS_PER_BIT cycles;
  - it asserts done for one cycle at the end of the stop bit;
  - tx_start while the serializer is active is ignored.

## Timing
- start sampled at edge k:
  - busy=1 and rd_addr=0 after edge k;
  - data captured at edge k+2;
  - tx falls (start bit) after edge k+3.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Inter-frame idle high gap:
  - within a row: exactly 3 cycles (done → FETCH → WAIT → LOAD);
  - before CR and LF bytes: exactly 1 cycle.
- done_tick is asserted the cycle after the final serializer done. busy falls on that same edge.
- Baud counter: ceil(log2(CLKS_PER_BIT)) bits. It reloads on every bit boundary with no cumulative drift.
- rd_addr is stable from FETCH through WAIT. rd_addr for row ROWS-1, col COLS-1 is {ROWS-1, COLS-1}. It never wraps past ROWS-1.

## Structure
- Shared package holds the constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_SPACE=8'h20, and the FSM state encoding.
- Sub-module uart_tx contains the baud counter, the bit counter, and the shift register.
  - Ports: clk, rst_n, tx_start, din[7:0], tx, tx_busy, tx_done_tick.
  - The top holds the scan FSM and the row/column counters.

## Test plan
Use COLS=4, ROWS=2, CLKS_PER_BIT=4 unless stated otherwise. The RAM model returns 0x41+col+4*row.

1. Single start → tx carries "ABCD\r\nEFGH\r\n" (12 frames, each 40 cycles). done_tick fires once. busy is high for the full dump.
2. Check the first frame bit-exact for 0x41. tx pattern per 4-cycle bit: 0,1,0,0,0,0,0,1,0,1. The start bit begins 3 cycles after start.
3. The RAM returns 0x07 at (0,1) and 0x7F at (1,2) → those frames carry 0x20. All other bytes are unchanged.
4. start re-pulsed at cycles 50 and 200 during a dump → output is identical to scenario 1. There is exactly one done_tick.
5. rst_n low mid-data-bit of frame 3 → tx=1 and busy=0 immediately. After release, a new start yields a full "ABCD…" dump from address 0.
6. Default parameters with all RAM = 0x20 → 2460 frames. The last byte is 0x0A. done_tick occurs 2460*26040 + inter-frame gaps after start, and rd_addr never exceeds {29,79}.

Source files
------------

// File: rtl/text_dump_tx_pkg.sv
// Shared constants, state encodings and the character substitution rule
// for the text-buffer UART dump.
package text_dump_tx_pkg;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      LOAD,
      SEND,
      EOL_CR,
      EOL_LF,
      FINISH
   } scan_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Control codes and DEL would upset a terminal capture, so they go out as spaces.
   function automatic logic [7:0] printable(input logic [6:0] c);
      return ((c < 7'h20) || (c == 7'h7F)) ? ASCII_SPACE : {1'b0, c};
   endfunction

endpackage

// File: rtl/text_dump_tx_uart.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, stop bit, each
// held CLKS_PER_BIT cycles; tx_done_tick marks the last stop-bit cycle.
module uart_tx
   import text_dump_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick
);

   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   assign bit_end = (baud_q == BAUD_LAST);
   assign tx      = tx_q;
   assign tx_busy = (state_q != TX_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Baud counter reloads at every bit boundary, so bit lengths never drift.
   always_comb begin
      state_d      = state_q;
      baud_d       = bit_end ? '0 : baud_q + BW'(1);
      bit_d        = bit_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      tx_done_tick = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            baud_d = '0;
            if (tx_start) begin
               shift_d = din;
               tx_d    = 1'b0;
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = TX_STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               tx_done_tick = 1'b1;
               state_d      = TX_IDLE;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/text_dump_tx.sv
// Scans the text buffer row by row and streams it over the UART, closing
// each row with CR/LF.
module text_dump_tx
   import text_dump_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604,
   parameter int COLS         = 80,
   parameter int ROWS         = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [11:0] rd_addr,
   input  logic [6:0]  rd_data,
   output logic        tx,
   output logic        busy,
   output logic        done_tick
);

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

   scan_state_t state_q, state_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [7:0]  byte_q, byte_d;
   logic        tx_start;
   logic [7:0]  tx_din;
   logic        tx_busy;
   logic        tx_done_tick;

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_start     (tx_start),
      .din          (tx_din),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
   );

   assign rd_addr   = {row_q, col_q};
   assign busy      = (state_q != IDLE) && (state_q != FINISH);
   assign done_tick = (state_q == FINISH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         byte_q  <= byte_d;
      end
   end

   // CR/LF states fire the serializer on their first (idle) cycle and then
   // wait in place, which gives the one-cycle gap ahead of line endings.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      byte_d   = byte_q;
      tx_start = 1'b0;
      tx_din   = byte_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               row_d   = '0;
               col_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            byte_d  = printable(rd_data);
            state_d = LOAD;
         end
         LOAD: begin
            tx_start = 1'b1;
            state_d  = SEND;
         end
         SEND: begin
            if (tx_done_tick) begin
               if (col_q != COL_LAST) begin
                  col_d   = col_q + 7'd1;
                  state_d = FETCH;
               end else begin
                  state_d = EOL_CR;
               end
            end
         end
         EOL_CR: begin
            tx_din   = ASCII_CR;
            tx_start = !tx_busy;
            if (tx_done_tick) state_d = EOL_LF;
         end
         EOL_LF: begin
            tx_din   = ASCII_LF;
            tx_start = !tx_busy;
            if (tx_done_tick) begin
               if (row_q != ROW_LAST) begin
                  row_d   = row_q + 5'd1;
                  col_d   = '0;
                  state_d = FETCH;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule
